lab1_imul_zero_skip_mul: RTL and testbench

LAB1_IMUL_ZERO_SKIP_MUL -- requirements
Module: lab1_imul_zero_skip_mul

---
 rtl/lab1_imul_zero_skip_mul.sv | 150 +++++++++++++++
 tb/tb_lab1_imul_zero_skip_mul.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_imul_zero_skip_mul.sv
// ---------------------------------------------------------------------------
// lab1_imul_zero_skip_mul
//
// Iterative shift-and-add integer multiplier with optional zero skipping.
// The block takes one pair of operands, iterates over the multiplier bits,
// and returns the product modulo 2^NBITS.
//
// Parameters
//   NBITS : operand and result width (default 32)
//   WIN   : zero-skip window in bits, legal range 2..NBITS (default 8)
//
// Configuration macro
//   LAB1_IMUL_ZERO_SKIP_EN
//     defined   : each iteration shifts by up to WIN positions, skipping runs
//                 of zero multiplier bits.
//     undefined : each iteration shifts by exactly one position.
//   Both builds produce identical products; only the latency differs.
//
// Ports
//   clk       in   1        sole clock, rising edge
//   reset     in   1        synchronous, active-high
//   req_val   in   1        request valid
//   req_rdy   out  1        block can accept a request (IDLE only)
//   req_msg   in   2*NBITS  {a, b}: a in the upper half, b in the lower half
//   resp_val  out  1        product valid (DONE only)
//   resp_rdy  in   1        consumer ready
//   resp_msg  out  NBITS    a*b modulo 2^NBITS
//   dbg_state out  2        current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where val and rdy are both
// high. val never depends on rdy; the producer holds val and msg stable until
// the transfer. req_rdy is high only in IDLE, resp_val is high only in DONE,
// and resp_msg is stable for as long as resp_val is high.
// ---------------------------------------------------------------------------
module lab1_imul_zero_skip_mul #(
  parameter int NBITS = 32,
  parameter int WIN   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*NBITS-1:0] req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [NBITS-1:0]   resp_msg,
  output logic [1:0]         dbg_state
);

  // Wide enough to hold the value WIN itself (all-zero window case).
  localparam int SHW = $clog2(WIN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [NBITS-1:0] a_reg;
  logic [NBITS-1:0] b_reg;
  logic [NBITS-1:0] acc;
  logic [SHW-1:0]   shamt;

  // -------------------------------------------------------------------------
  // Shift amount for the current CALC iteration.
  // -------------------------------------------------------------------------
`ifdef LAB1_IMUL_ZERO_SKIP_EN
  // Look at the low WIN bits of b:
  //   all zero      -> skip the whole window
  //   b[0] set      -> consume just that bit (its add happens this cycle)
  //   otherwise     -> jump straight to the lowest set bit
  // The loop runs high-to-low so the last hit is the lowest set bit.
  always_comb begin
    shamt = SHW'(WIN);
    if (b_reg[0]) begin
      shamt = SHW'(1);
    end else if (b_reg[WIN-1:0] != '0) begin
      for (int i = WIN - 1; i >= 1; i--) begin
        if (b_reg[i]) begin
          shamt = SHW'(i);
        end
      end
    end
  end
`else
  // Plain radix-2 iteration: one multiplier bit per cycle.
  assign shamt = SHW'(1);
`endif

  // -------------------------------------------------------------------------
  // Control FSM and datapath. req_rdy and resp_val are registered alongside
  // the state so they track it exactly.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val && req_rdy) begin
            a_reg   <= req_msg[2*NBITS-1:NBITS];
            b_reg   <= req_msg[NBITS-1:0];
            acc     <= '0;
            state   <= CALC;
            req_rdy <= 1'b0;
          end
        end

        CALC: begin
          if (b_reg == '0) begin
            // No multiplier bits left: finish without touching the datapath.
            state    <= DONE;
            resp_val <= 1'b1;
          end else begin
            if (b_reg[0]) begin
              acc <= acc + a_reg;
            end
            a_reg <= a_reg << shamt;
            b_reg <= b_reg >> shamt;
          end
        end

        DONE: begin
          // Everything stays frozen while the consumer stalls.
          if (resp_val && resp_rdy) begin
            state    <= IDLE;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          req_rdy  <= 1'b1;
          resp_val <= 1'b0;
        end
      endcase
    end
  end

  assign resp_msg  = acc;
  assign dbg_state = state;

endmodule

// File: tb/tb_lab1_imul_zero_skip_mul.sv
// ---------------------------------------------------------------------------
// Testbench for lab1_imul_zero_skip_mul (NBITS=32, WIN=8).
// Builds in either shift mode; hand latencies follow LAB1_IMUL_ZERO_SKIP_EN.
// ---------------------------------------------------------------------------
module tb_lab1_imul_zero_skip_mul;

  localparam int NBITS = 32;
  localparam int WIN   = 8;
  localparam int BOUND = 200;

`ifdef LAB1_IMUL_ZERO_SKIP_EN
  localparam int LAT_B31   = 7;
  localparam int LAT_B100  = 4;
  localparam int LAT_B81   = 5;
  localparam int CALC_B31  = 6;
`else
  localparam int LAT_B31   = 34;
  localparam int LAT_B100  = 11;
  localparam int LAT_B81   = 10;
  localparam int CALC_B31  = 33;
`endif

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               reset;
  logic               req_val;
  logic               req_rdy;
  logic [2*NBITS-1:0] req_msg;
  logic               resp_val;
  logic               resp_rdy;
  logic [NBITS-1:0]   resp_msg;
  logic [1:0]         dbg_state;

  always #5 clk = ~clk;

  lab1_imul_zero_skip_mul #(.NBITS(NBITS), .WIN(WIN)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_msg   (req_msg),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_msg  (resp_msg),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [NBITS-1:0] model_prod(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    return a * b;
  endfunction

  // Number of cycles spent in CALC for multiplier b: one per consumed chunk
  // of b, plus the final cycle that observes b == 0.
  function automatic int model_calc(input logic [NBITS-1:0] b);
    int n;
    int tz;
    n = 1;
    while (b != 0) begin
`ifdef LAB1_IMUL_ZERO_SKIP_EN
      if (b[0]) begin
        b = b >> 1;
      end else if (b[WIN-1:0] == 0) begin
        b = b >> WIN;
      end else begin
        tz = 0;
        while (!b[tz]) tz++;
        b = b >> tz;
      end
`else
      b = b >> 1;
`endif
      n++;
    end
    return n;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [NBITS-1:0] exp_q[$];
  int               lat_q[$];
  bit               pending = 0;
  bit               seen = 0;
  int               cnt = 0;
  int               cyc = 0;
  int               accept_cyc = 0;
  int               xfer_cyc = 0;
  int               resp_count = 0;
  logic [NBITS-1:0] last_resp = '0;
  int               last_lat = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      lat_q.delete();
      pending = 0;
      seen    = 0;
    end else begin
      check("rdy_and_val_together", {63'd0, req_rdy & resp_val}, 64'd0);
      if (pending) begin
        cnt++;
        check("req_rdy_busy", {63'd0, req_rdy}, 64'd0);
        if (resp_val) begin
          if (!seen) begin
            seen     = 1;
            last_lat = cnt;
            check("latency", cnt, lat_q[0]);
          end
          check("resp_msg", resp_msg, exp_q[0]);
          if (resp_rdy) begin
            xfer_cyc  = cyc;
            last_resp = resp_msg;
            resp_count++;
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            pending = 0;
            seen    = 0;
          end
        end
      end else begin
        check("resp_val_when_idle", {63'd0, resp_val}, 64'd0);
        check("req_rdy_when_idle", {63'd0, req_rdy}, 64'd1);
        if (req_val && req_rdy) begin
          exp_q.push_back(model_prod(req_msg[2*NBITS-1:NBITS], req_msg[NBITS-1:0]));
          lat_q.push_back(model_calc(req_msg[NBITS-1:0]) + 1);
          pending    = 1;
          cnt        = 0;
          accept_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    int k;
    @(posedge clk); #1;
    req_val = 1'b1;
    req_msg = {a, b};
    for (k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (req_rdy) break;
    end
    if (k == BOUND) check("timeout_accept", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic wait_resp(input int prev);
    int k;
    for (k = 0; k < BOUND; k++) begin
      @(posedge clk);
      if (resp_count > prev) break;
    end
    if (k == BOUND) check("timeout_resp", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                        input logic [NBITS-1:0] exp_p, input int exp_lat);
    int prev;
    prev = resp_count;
    send(a, b);
    wait_resp(prev);
    check({name, "_prod"}, last_resp, exp_p);
    check({name, "_lat"}, last_lat, exp_lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int k;
    int prev;
    reset    = 1'b1;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b1;

    // pin the model with hand-computed values
    check("model_prod_3x5", model_prod(32'd3, 32'd5), 64'd15);
    check("model_calc_b5", model_calc(32'd5), 64'd4);
    check("model_calc_b0", model_calc(32'd0), 64'd1);
    check("model_calc_b31", model_calc(32'h8000_0000), CALC_B31);
    check("model_prod_wrap", model_prod(32'hFFFF_FFFF, 32'd2), 64'hFFFF_FFFE);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_rdy", {63'd0, req_rdy}, 64'd1);
    check("rst_resp_val", {63'd0, resp_val}, 64'd0);
    check("rst_resp_msg", resp_msg, 64'd0);
    check("rst_state", dbg_state, 64'd0);

    // directed operations
    run_op("a3_b5",      32'd3,         32'd5,         32'd15,         5);
    run_op("a1_b31",     32'd1,         32'h8000_0000, 32'h8000_0000,  LAT_B31);
    run_op("a7_b0",      32'd7,         32'd0,         32'd0,          2);
    run_op("wrap",       32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE,  4);
    run_op("win_zero",   32'h100,       32'h100,       32'h1_0000,     LAT_B100);
    run_op("a5_b81",     32'd5,         32'h81,        32'd645,        LAT_B81);
    run_op("a12345",     32'd12345,     32'd678,       32'd8369910,    model_calc(32'd678) + 1);
    run_op("deadbeef",   32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF * 32'h1234_5678,
           model_calc(32'h1234_5678) + 1);

    // backpressure: consumer stalls, a new request waits meanwhile
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    prev = resp_count;
    send(32'd6, 32'd7);
    for (k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (resp_val) break;
    end
    if (k == BOUND) check("timeout_bp_val", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_val = 1'b1;
    req_msg = {32'd9, 32'd9};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_resp_val", {63'd0, resp_val}, 64'd1);
      check("bp_resp_msg", resp_msg, 64'd42);
      check("bp_req_rdy", {63'd0, req_rdy}, 64'd0);
    end
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    wait_resp(prev);
    check("bp_prod", last_resp, 64'd42);
    for (k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (req_rdy) break;
    end
    if (k == BOUND) check("timeout_bp_accept", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
    check("bp_accept_delay", accept_cyc - xfer_cyc, 64'd1);
    wait_resp(prev + 1);
    check("bp_second_prod", last_resp, 64'd81);

    // reset during the second CALC cycle
    send(32'd1, 32'h8000_0000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_rdy", {63'd0, req_rdy}, 64'd1);
    check("abort_resp_val", {63'd0, resp_val}, 64'd0);
    check("abort_resp_msg", resp_msg, 64'd0);
    run_op("after_abort", 32'd2, 32'd3, 32'd6, 4);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
